alu_station: RTL and testbench
==============================

# alu_station

Single-entry ALU reservation station directly downstream of the dispatch allocator; one instance per ALU slot (master/slave). Accepts one issued ALU operation with operand data or pending tags, snoops the three write-back buses until both operands are unlocked, executes, and broadcasts the result on its own write-back bus for one cycle. Its `busy_out` feeds the allocator's `aluN_busy_in`.

## Interface
Parameters:
- `MY_TAG`, default `` `ALU_MASTER `` (3'd1): tag this station owns; set to `` `ALU_SALVER `` for the slave instance.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  **asynchronous, active-low** reset (`rst`=0 resets).
- `alu_en_in`  in  1  issue strobe from allocator.
- `alu_pc_in`  in  32  instruction PC.
- `alu_op_in`  in  4  ALU sub-op (`sinst_t`).
- `alu_tagx_in`, `alu_tagy_in`  in  3  operand tags; `` `UNLOCKED `` = data valid.
- `alu_datax_in`, `alu_datay_in`  in  32  operand data.
- `alu_tagw_in`  in  3  destination tag (informational, not checked).
- `alu_addrw_in`  in  5  destination register.
- `en_mw0/1/2`, `reg_write_addr0/1/2`, `write_data0/1/2`  in  1/5/32  snooped write-back buses; bus 0 = `` `ALU_MASTER ``, bus 1 = `` `ALU_SALVER ``, bus 2 = `` `LOAD_STORE ``.
- `flush_in`  in  1  synchronous kill from branch unit.
- `busy_out`  out  1  station occupied.
- `en_mw_out`, `reg_write_addr_out`, `write_data_out`  out  1/5/32  own write-back bus.

## Operation
- States: IDLE, WAIT, DONE. Reset -> IDLE; all outputs 0.
- IDLE: `alu_en_in`=1 -> latch pc/op/addrw/tags/data -> WAIT.
- WAIT: every edge, for each operand whose latched tag is not `` `UNLOCKED ``: if the bus for that tag has `en_mw`=1, latch its data, set tag `` `UNLOCKED ``. When both latched tags are `` `UNLOCKED `` at the start of a cycle, compute and register result, `en_mw_out`<=1, -> DONE.
- DONE: `en_mw_out`=1 for exactly this cycle. `alu_en_in`=1 -> latch new op -> WAIT; else -> IDLE. `en_mw_out` cleared at the edge.
- `busy_out` = (state==WAIT). Low in DONE so the allocator can issue back-to-back.
- Ops (32-bit, wraparound): 0 ADD x+y, 1 SUB x-y, 2 SLL x<<y[4:0], 3 SLT signed, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI -> y, 11 AUIPC -> pc+y, 12 LINK -> pc+4; 13-15 -> 0.
- `reg_write_addr_out` = latched `addrw`; x0 destination still broadcast (regfile drops it).
- `flush_in`=1: next state IDLE, `en_mw_out`<=0, any same-cycle issue dropped; flush has priority over all other transitions.
- `alu_en_in` while in WAIT is an allocator error; ignored.

## Timing
- Base latency: issue at edge E0 with ready operands -> result computed at E1 -> `en_mw_out` high cycle E1..E2.
- Operand arriving on a bus in cycle C (sampled at edge Ec) -> compute at Ec+1.
- Reset asserted mid-WAIT or mid-DONE: immediate return to IDLE, `en_mw_out`=0, no broadcast.

## Configuration
- `ALU_BYPASS_EN` defined: readiness includes same-cycle snoop hits; an operand matched on a bus this cycle counts as ready and its bus data feeds the ALU directly; issue with both operands ready goes IDLE/DONE -> DONE in one edge (latency 1: broadcast in cycle after issue edge).
- Undefined: readiness uses latched tags only (latencies above).

## Structure
- Shared defines header: `word_t`, `addr_t`, `regtag_t`, `regaddr_t`, `sinst_t`, tag constants (`` `UNLOCKED ``=0, `` `ALU_MASTER ``, `` `ALU_SALVER ``, `` `LOAD_STORE ``, `` `BRANCH_SEL ``), ALU op codes 0-12, `` `WRITE_VAR_DEFINE ``.
- Sub-module `alu_core`: combinational op/pc/x/y -> result; reused by both station instances.

## Test plan
- Issue ADD x=5,y=7 both UNLOCKED at E0 -> `en_mw_out`=1 with `write_data_out`=12, `reg_write_addr_out`=addrw, one cycle starting after E1; `busy_out` 1 for one cycle.
- Issue SUB tagx=`` `LOAD_STORE ``, y=3; pulse `en_mw2`, `write_data2`=10 two cycles later -> result 7 broadcast one edge after snoop (no bypass) / same edge (bypass).
- Back-to-back: second issue in DONE cycle -> both results broadcast, no idle gap beyond WAIT.
- SRA x=0x80000000, y=0x21 -> 0xC0000000 (shift uses y[4:0]=1); SLTU 1 vs 0xFFFFFFFF -> 1.
- `flush_in` while WAIT with pending tag -> IDLE next edge, later matching bus write produces no `en_mw_out`.
- `rst`=0 asynchronously during DONE -> `en_mw_out`, `busy_out` drop immediately to 0.

Source files
------------

// File: rtl/alu_station_pkg.sv
// alu_station_pkg: shared types, tag constants, ALU op codes and snoop helpers
// for the ALU reservation stations.
// Optional feature macro used by alu_station: ALU_BYPASS_EN.
package alu_station_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [2:0]  regtag_t;
  typedef logic [4:0]  regaddr_t;

  // ALU sub-operations; codes 13..15 are reserved and produce zero
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_LUI   = 4'd10,
    OP_AUIPC = 4'd11,
    OP_LINK  = 4'd12
  } sinst_t;

  // Register tags: UNLOCKED means the operand data is already valid
  localparam regtag_t UNLOCKED   = 3'd0;
  localparam regtag_t ALU_MASTER = 3'd1;
  localparam regtag_t ALU_SALVER = 3'd2;
  localparam regtag_t LOAD_STORE = 3'd3;
  localparam regtag_t BRANCH_SEL = 3'd4;

  // Does the write-back bus owned by 'tag' fire this cycle?
  // Bus 0 = ALU_MASTER, bus 1 = ALU_SALVER, bus 2 = LOAD_STORE.
  function automatic logic tag_hit(input regtag_t tag, input logic [2:0] en);
    logic hit;
    case (tag)
      ALU_MASTER:           hit = en[0];
      ALU_SALVER:           hit = en[1];
      LOAD_STORE:           hit = en[2];
      UNLOCKED, BRANCH_SEL: hit = 1'b0;
      default:              hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Data carried by the write-back bus owned by 'tag'
  function automatic word_t tag_data(input regtag_t tag, input word_t d0,
                                     input word_t d1, input word_t d2);
    word_t d;
    case (tag)
      ALU_MASTER: d = d0;
      ALU_SALVER: d = d1;
      LOAD_STORE: d = d2;
      default:    d = 32'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_station_if.sv
// alu_station_if: issue port, the three snooped write-back buses, the flush
// strobe and the station's own write-back bus.
interface alu_station_if;
  import alu_station_pkg::*;

  // issue from allocator
  logic     alu_en_in;
  addr_t    alu_pc_in;
  sinst_t   alu_op_in;
  regtag_t  alu_tagx_in;
  regtag_t  alu_tagy_in;
  word_t    alu_datax_in;
  word_t    alu_datay_in;
  regtag_t  alu_tagw_in;
  regaddr_t alu_addrw_in;
  // snooped write-back buses
  logic     en_mw0;
  logic     en_mw1;
  logic     en_mw2;
  regaddr_t reg_write_addr0;
  regaddr_t reg_write_addr1;
  regaddr_t reg_write_addr2;
  word_t    write_data0;
  word_t    write_data1;
  word_t    write_data2;
  // branch kill
  logic     flush_in;
  // station status and own write-back bus
  logic     busy_out;
  logic     en_mw_out;
  regaddr_t reg_write_addr_out;
  word_t    write_data_out;

  modport master (
    output alu_en_in, alu_pc_in, alu_op_in, alu_tagx_in, alu_tagy_in,
           alu_datax_in, alu_datay_in, alu_tagw_in, alu_addrw_in,
           en_mw0, en_mw1, en_mw2, reg_write_addr0, reg_write_addr1,
           reg_write_addr2, write_data0, write_data1, write_data2, flush_in,
    input  busy_out, en_mw_out, reg_write_addr_out, write_data_out
  );

  modport slave (
    input  alu_en_in, alu_pc_in, alu_op_in, alu_tagx_in, alu_tagy_in,
           alu_datax_in, alu_datay_in, alu_tagw_in, alu_addrw_in,
           en_mw0, en_mw1, en_mw2, reg_write_addr0, reg_write_addr1,
           reg_write_addr2, write_data0, write_data1, write_data2, flush_in,
    output busy_out, en_mw_out, reg_write_addr_out, write_data_out
  );

endinterface

// File: rtl/alu_station_alu_core.sv
// alu_core: purely combinational ALU shared by the master and slave stations.
// Shifts use only the low five bits of y; all arithmetic wraps at 32 bits.
module alu_core
  import alu_station_pkg::*;
(
  input  sinst_t op,
  input  addr_t  pc,
  input  word_t  x,
  input  word_t  y,
  output word_t  result
);

  logic [4:0] shamt_s;

  assign shamt_s = y[4:0];

  // Select the operation result
  always_comb begin
    result = 32'd0;
    case (op)
      OP_ADD:   result = x + y;
      OP_SUB:   result = x - y;
      OP_SLL:   result = x << shamt_s;
      OP_SLT:   result = {31'd0, ($signed(x) < $signed(y))};
      OP_SLTU:  result = {31'd0, (x < y)};
      OP_XOR:   result = x ^ y;
      OP_SRL:   result = x >> shamt_s;
      OP_SRA:   result = word_t'($signed(x) >>> shamt_s);
      OP_OR:    result = x | y;
      OP_AND:   result = x & y;
      OP_LUI:   result = y;
      OP_AUIPC: result = pc + y;
      OP_LINK:  result = pc + 32'd4;
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_station.sv
// alu_station: single-entry ALU reservation station. Holds one issued op,
// snoops the three write-back buses until both operands are valid, executes
// and broadcasts the result on its own bus for one cycle.
// Build option: define ALU_BYPASS_EN to let same-cycle snoop hits count as
// ready (operand data forwarded straight from the bus into the ALU).
module alu_station
  import alu_station_pkg::*;
#(
  parameter regtag_t MY_TAG = ALU_MASTER
)(
  input logic         clk,
  input logic         rst,
  alu_station_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_r, state_s;
  addr_t      pc_r, pc_s;
  sinst_t     op_r, op_s;
  regaddr_t   addrw_r, addrw_s;
  regtag_t    tagx_r, tagx_s, tagy_r, tagy_s;
  word_t      datax_r, datax_s, datay_r, datay_s;
  logic       busy_r, busy_s;
  logic       en_r, en_s;
  regaddr_t   waddr_r, waddr_s;
  word_t      wdata_r, wdata_s;

  // operand source: latched entry while waiting, issue port otherwise
  addr_t      src_pc_s;
  sinst_t     src_op_s;
  regtag_t    src_tagx_s, src_tagy_s;
  word_t      src_datax_s, src_datay_s;

  logic [2:0] en_vec_s;
  logic       snoop_act_s;
  logic       x_hit_s, y_hit_s;
  regtag_t    x_tag_upd_s, y_tag_upd_s;
  word_t      x_data_upd_s, y_data_upd_s;
  logic       x_rdy_s, y_rdy_s;
  logic       issue_fast_s;
  word_t      core_x_s, core_y_s, core_res_s;

  // The destination tag and the snooped bus addresses are informational only;
  // operands are matched purely by producer tag.
  logic unused_s;
  assign unused_s = ^{MY_TAG, bus.alu_tagw_in, bus.reg_write_addr0,
                      bus.reg_write_addr1, bus.reg_write_addr2};

  assign en_vec_s = {bus.en_mw2, bus.en_mw1, bus.en_mw0};

`ifdef ALU_BYPASS_EN
  assign snoop_act_s  = 1'b1;
  assign x_rdy_s      = (x_tag_upd_s == UNLOCKED);
  assign y_rdy_s      = (y_tag_upd_s == UNLOCKED);
  assign core_x_s     = x_data_upd_s;
  assign core_y_s     = y_data_upd_s;
  assign issue_fast_s = x_rdy_s && y_rdy_s;
`else
  assign snoop_act_s  = (state_r == S_WAIT);
  assign x_rdy_s      = (src_tagx_s == UNLOCKED);
  assign y_rdy_s      = (src_tagy_s == UNLOCKED);
  assign core_x_s     = src_datax_s;
  assign core_y_s     = src_datay_s;
  assign issue_fast_s = 1'b0;
`endif

  // Pick the operand source for this cycle
  always_comb begin
    if (state_r == S_WAIT) begin
      src_pc_s    = pc_r;
      src_op_s    = op_r;
      src_tagx_s  = tagx_r;
      src_tagy_s  = tagy_r;
      src_datax_s = datax_r;
      src_datay_s = datay_r;
    end else begin
      src_pc_s    = bus.alu_pc_in;
      src_op_s    = bus.alu_op_in;
      src_tagx_s  = bus.alu_tagx_in;
      src_tagy_s  = bus.alu_tagy_in;
      src_datax_s = bus.alu_datax_in;
      src_datay_s = bus.alu_datay_in;
    end
  end

  // Apply write-back bus hits to still-locked operands
  always_comb begin
    x_hit_s = snoop_act_s && (src_tagx_s != UNLOCKED) && tag_hit(src_tagx_s, en_vec_s);
    y_hit_s = snoop_act_s && (src_tagy_s != UNLOCKED) && tag_hit(src_tagy_s, en_vec_s);
    if (x_hit_s) begin
      x_tag_upd_s  = UNLOCKED;
      x_data_upd_s = tag_data(src_tagx_s, bus.write_data0, bus.write_data1, bus.write_data2);
    end else begin
      x_tag_upd_s  = src_tagx_s;
      x_data_upd_s = src_datax_s;
    end
    if (y_hit_s) begin
      y_tag_upd_s  = UNLOCKED;
      y_data_upd_s = tag_data(src_tagy_s, bus.write_data0, bus.write_data1, bus.write_data2);
    end else begin
      y_tag_upd_s  = src_tagy_s;
      y_data_upd_s = src_datay_s;
    end
  end

  alu_core u_core (
    .op     (src_op_s),
    .pc     (src_pc_s),
    .x      (core_x_s),
    .y      (core_y_s),
    .result (core_res_s)
  );

  // Next-state and next-output decision; flush overrides everything
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    op_s    = op_r;
    addrw_s = addrw_r;
    tagx_s  = tagx_r;
    tagy_s  = tagy_r;
    datax_s = datax_r;
    datay_s = datay_r;
    en_s    = 1'b0;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    if (bus.flush_in) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_WAIT: begin
          // issue strobes seen here are allocator errors and are ignored
          if (x_rdy_s && y_rdy_s) begin
            state_s = S_DONE;
            en_s    = 1'b1;
            waddr_s = addrw_r;
            wdata_s = core_res_s;
          end else begin
            tagx_s  = x_tag_upd_s;
            tagy_s  = y_tag_upd_s;
            datax_s = x_data_upd_s;
            datay_s = y_data_upd_s;
          end
        end
        S_IDLE, S_DONE: begin
          if (bus.alu_en_in) begin
            pc_s    = bus.alu_pc_in;
            op_s    = bus.alu_op_in;
            addrw_s = bus.alu_addrw_in;
            tagx_s  = x_tag_upd_s;
            tagy_s  = y_tag_upd_s;
            datax_s = x_data_upd_s;
            datay_s = y_data_upd_s;
            if (issue_fast_s) begin
              state_s = S_DONE;
              en_s    = 1'b1;
              waddr_s = bus.alu_addrw_in;
              wdata_s = core_res_s;
            end else begin
              state_s = S_WAIT;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
    busy_s = (state_s == S_WAIT);
  end

  // State and output registers; reset returns to IDLE with a silent bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      pc_r    <= 32'd0;
      op_r    <= OP_ADD;
      addrw_r <= 5'd0;
      tagx_r  <= UNLOCKED;
      tagy_r  <= UNLOCKED;
      datax_r <= 32'd0;
      datay_r <= 32'd0;
      busy_r  <= 1'b0;
      en_r    <= 1'b0;
      waddr_r <= 5'd0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      op_r    <= op_s;
      addrw_r <= addrw_s;
      tagx_r  <= tagx_s;
      tagy_r  <= tagy_s;
      datax_r <= datax_s;
      datay_r <= datay_s;
      busy_r  <= busy_s;
      en_r    <= en_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
    end
  end

  assign bus.busy_out           = busy_r;
  assign bus.en_mw_out          = en_r;
  assign bus.reg_write_addr_out = waddr_r;
  assign bus.write_data_out     = wdata_r;

endmodule

// File: tb/tb_alu_station.sv
// tb_alu_station: directed and randomized checks of alu_station against a
// transaction-level model (expected result from plain arithmetic, expected
// broadcast cycle from operand arrival times).
module tb_alu_station;
  import alu_station_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [4:0]  addrw;
    logic [2:0]  tagx;
    logic [31:0] dx;
    int          kx;
    logic [2:0]  tagy;
    logic [31:0] dy;
    int          ky;
  } txn_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   txn_id;

  alu_station_if bus ();

  alu_station #(.MY_TAG(ALU_MASTER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (txn %0d): observed %0h expected %0h", tag, txn_id, obs, exp);
    end
  endtask

  // Reference ALU: result of each op from its arithmetic definition
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] pc,
                                          input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    logic signed [31:0] sx;
    logic [31:0] r;
    sh = y % 32;
    sx = x;
    case (op)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x << sh;
      4'd3:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4:  r = (x < y) ? 32'd1 : 32'd0;
      4'd5:  r = x ^ y;
      4'd6:  r = x >> sh;
      4'd7:  r = sx >>> sh;
      4'd8:  r = x | y;
      4'd9:  r = x & y;
      4'd10: r = y;
      4'd11: r = pc + y;
      4'd12: r = pc + 32'd4;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic txn_t mk(input logic [3:0] op, input logic [31:0] pc, input logic [4:0] addrw,
                              input logic [2:0] tagx, input logic [31:0] dx, input int kx,
                              input logic [2:0] tagy, input logic [31:0] dy, input int ky);
    txn_t t;
    t.op = op; t.pc = pc; t.addrw = addrw;
    t.tagx = tagx; t.dx = dx; t.kx = kx;
    t.tagy = tagy; t.dy = dy; t.ky = ky;
    return t;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0:       w = 32'($urandom_range(0, 40));
      1:       w = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2:       w = 32'h8000_0000 | 32'($urandom_range(0, 64));
      default: w = $urandom;
    endcase
    return w;
  endfunction

  task automatic clear_inputs();
    bus.alu_en_in = 1'b0;
    bus.en_mw0 = 1'b0;
    bus.en_mw1 = 1'b0;
    bus.en_mw2 = 1'b0;
  endtask

  task automatic drive_bus(input logic [2:0] tag, input logic [31:0] d);
    case (tag)
      3'd1: begin bus.en_mw0 = 1'b1; bus.write_data0 = d; bus.reg_write_addr0 = 5'($urandom); end
      3'd2: begin bus.en_mw1 = 1'b1; bus.write_data1 = d; bus.reg_write_addr1 = 5'($urandom); end
      3'd3: begin bus.en_mw2 = 1'b1; bus.write_data2 = d; bus.reg_write_addr2 = 5'($urandom); end
      default: ;
    endcase
  endtask

  task automatic drive_issue(input txn_t t);
    bus.alu_en_in    = 1'b1;
    bus.alu_pc_in    = t.pc;
    bus.alu_op_in    = sinst_t'(t.op);
    bus.alu_addrw_in = t.addrw;
    bus.alu_tagw_in  = ALU_MASTER;
    bus.alu_tagx_in  = t.tagx;
    bus.alu_tagy_in  = t.tagy;
    bus.alu_datax_in = (t.tagx != 3'd0) ? $urandom : t.dx;
    bus.alu_datay_in = (t.tagy != 3'd0) ? $urandom : t.dy;
  endtask

  // Issue one op, deliver pending operands at their edges and check every
  // cycle until one cycle after the broadcast (or stop in the DONE cycle).
  task automatic run_txn(input txn_t t, input bit stop_in_done, input bit from_done);
    int kmax;
    int d;
    logic [31:0] exp_res;
    txn_id++;
    kmax = (t.kx > t.ky) ? t.kx : t.ky;
`ifdef ALU_BYPASS_EN
    d = kmax;
`else
    d = kmax + 1;
`endif
    exp_res = ref_alu(t.op, t.pc, t.dx, t.dy);
    if (!from_done) @(negedge clk);
    drive_issue(t);
    @(posedge clk);
    for (int j = 0; j <= d + 1; j++) begin
      @(negedge clk);
      clear_inputs();
      chk("busy", {31'd0, bus.busy_out}, (j < d) ? 32'd1 : 32'd0);
      chk("en_mw_out", {31'd0, bus.en_mw_out}, (j == d) ? 32'd1 : 32'd0);
      if (j == d) begin
        chk("write_data", bus.write_data_out, exp_res);
        chk("write_addr", {27'd0, bus.reg_write_addr_out}, {27'd0, t.addrw});
        if (stop_in_done) return;
      end
      if (j == d + 1) break;
      if (t.tagx != 3'd0 && t.kx == j + 1) drive_bus(t.tagx, t.dx);
      if (t.tagy != 3'd0 && t.ky == j + 1) drive_bus(t.tagy, t.dy);
      for (int b = 1; b <= 3; b++) begin
        if (3'(b) != t.tagx && 3'(b) != t.tagy && $urandom_range(0, 3) == 0)
          drive_bus(3'(b), $urandom);
      end
      if (j < d && $urandom_range(0, 3) == 0) begin
        bus.alu_en_in    = 1'b1;
        bus.alu_op_in    = sinst_t'(4'($urandom));
        bus.alu_pc_in    = $urandom;
        bus.alu_tagx_in  = 3'd0;
        bus.alu_tagy_in  = 3'd0;
        bus.alu_datax_in = $urandom;
        bus.alu_datay_in = $urandom;
        bus.alu_addrw_in = 5'($urandom);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    txn_t t;
    bit   prev_done;
    bit   stop;
    n_cmp = 0;
    n_fail = 0;
    txn_id = 0;
    rst = 1'b0;
    bus.alu_pc_in = 32'd0; bus.alu_op_in = OP_ADD; bus.alu_tagx_in = 3'd0;
    bus.alu_tagy_in = 3'd0; bus.alu_datax_in = 32'd0; bus.alu_datay_in = 32'd0;
    bus.alu_tagw_in = 3'd0; bus.alu_addrw_in = 5'd0; bus.flush_in = 1'b0;
    bus.reg_write_addr0 = 5'd0; bus.reg_write_addr1 = 5'd0; bus.reg_write_addr2 = 5'd0;
    bus.write_data0 = 32'd0; bus.write_data1 = 32'd0; bus.write_data2 = 32'd0;
    clear_inputs();

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_en", {31'd0, bus.en_mw_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("rst_data", bus.write_data_out, 32'd0);
    chk("rst_addr", {27'd0, bus.reg_write_addr_out}, 32'd0);
    rst = 1'b1;

    // ADD with ready operands
    run_txn(mk(4'd0, 32'h100, 5'd7, 3'd0, 32'd5, 0, 3'd0, 32'd7, 0), 1'b0, 1'b0);
    // SUB waiting on load/store bus, delivered two edges after issue
    run_txn(mk(4'd1, 32'h104, 5'd9, LOAD_STORE, 32'd10, 2, 3'd0, 32'd3, 0), 1'b0, 1'b0);
    // SRA by y[4:0]=1 and SLTU boundary
    run_txn(mk(4'd7, 32'h108, 5'd3, 3'd0, 32'h8000_0000, 0, 3'd0, 32'h21, 0), 1'b0, 1'b0);
    run_txn(mk(4'd4, 32'h10C, 5'd4, 3'd0, 32'd1, 0, 3'd0, 32'hFFFF_FFFF, 0), 1'b0, 1'b0);
    // x0 destination still broadcast; both operands from distinct buses
    run_txn(mk(4'd10, 32'h110, 5'd0, ALU_SALVER, 32'h1234_5000, 1, ALU_MASTER, 32'hABCD_0000, 3), 1'b0, 1'b0);
    // back-to-back: second issue in the DONE cycle
    run_txn(mk(4'd0, 32'h200, 5'd1, 3'd0, 32'd100, 0, 3'd0, 32'd23, 0), 1'b1, 1'b0);
    run_txn(mk(4'd12, 32'h204, 5'd2, 3'd0, 32'd0, 0, 3'd0, 32'd0, 0), 1'b0, 1'b1);

    // flush while waiting on a pending tag; the late bus write must not fire
    txn_id++;
    @(negedge clk);
    drive_issue(mk(4'd1, 32'h300, 5'd5, LOAD_STORE, 32'd0, 0, 3'd0, 32'd3, 0));
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    chk("flush_pre_busy", {31'd0, bus.busy_out}, 32'd1);
    bus.flush_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_in = 1'b0;
    chk("flush_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("flush_en", {31'd0, bus.en_mw_out}, 32'd0);
    drive_bus(LOAD_STORE, 32'd10);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      chk("flush_late_en", {31'd0, bus.en_mw_out}, 32'd0);
      chk("flush_late_busy", {31'd0, bus.busy_out}, 32'd0);
    end

    // issue in the same cycle as flush is dropped
    txn_id++;
    drive_issue(mk(4'd0, 32'h310, 5'd6, 3'd0, 32'd1, 0, 3'd0, 32'd2, 0));
    bus.flush_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    bus.flush_in = 1'b0;
    chk("flush_issue_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("flush_issue_en", {31'd0, bus.en_mw_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flush_issue_en2", {31'd0, bus.en_mw_out}, 32'd0);

    // randomized transactions, some chained back-to-back
    prev_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      t.op = 4'($urandom_range(0, 15));
      t.pc = $urandom & 32'hFFFF_FFFC;
      t.addrw = 5'($urandom);
      t.dx = rnd_word();
      t.dy = rnd_word();
      t.tagx = 3'd0; t.kx = 0;
      t.tagy = 3'd0; t.ky = 0;
      if ($urandom_range(0, 1) == 1) begin
        t.tagx = 3'($urandom_range(1, 3));
        t.kx = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 1) == 1) begin
        t.tagy = 3'($urandom_range(1, 3));
        t.ky = $urandom_range(1, 4);
        if (t.tagy == t.tagx) begin
          t.ky = t.kx;
          t.dy = t.dx;
        end
      end
      stop = (i != 59) && ($urandom_range(0, 2) == 0);
      run_txn(t, stop, prev_done);
      prev_done = stop;
    end

    // asynchronous reset during DONE silences the bus immediately
    run_txn(mk(4'd5, 32'h400, 5'd12, 3'd0, 32'hF0F0_F0F0, 0, 3'd0, 32'h0FF0_0FF0, 0), 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_en", {31'd0, bus.en_mw_out}, 32'd0);
    chk("async_rst_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("async_rst_data", bus.write_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("post_rst_en", {31'd0, bus.en_mw_out}, 32'd0);
    run_txn(mk(4'd11, 32'h500, 5'd13, ALU_MASTER, 32'd16, 1, 3'd0, 32'd0, 0), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
